// File: rtl/rr_arb8_if.sv
// rr_arb8_if: request/grant bundle between requesters and the round-robin
// arbiter.
//   req[7:0]     requester i asserts bit i
//   done         release strobe from the current owner
//   gnt[7:0]     one-hot grant, zero while no grant is held
//   gnt_idx[2:0] binary index of the granted requester
//   gnt_valid    high while a grant is held
//   timeout      one-cycle pulse after a forced release at the hold limit
interface rr_arb8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arb8.sv
// rr_arb8: 8-way round-robin arbiter with a bounded hold time.
//   clk      single clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      rr_arb8_if.slave (req, done in; gnt, gnt_idx, gnt_valid, timeout out)
//   HOLD_MAX maximum consecutive cycles a grant is held (2..256)
//
// state | meaning
// IDLE  | no grant held; arbitrate from ptr on the next edge
// GRANT | gnt_idx owns the resource; cnt counts held cycles from 0
module rr_arb8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  rr_arb8_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  // Last cnt value before a forced release; HOLD_MAX=256 still fits 8 bits.
  localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;

  logic [2:0] pick_idx;
  logic       pick_found;
  logic [2:0] cand;
  logic       rel_norm;
  logic       rel_to;

  // Rotating priority search: first set request at ptr, ptr+1, ... mod 8.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = '0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    rel_norm  = bus.done || !bus.req[idx_q];
    rel_to    = (cnt_q == CNT_LAST);
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          idx_d   = pick_idx;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel_norm || rel_to) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          ptr_d     = idx_q + 3'd1;
          // Pulse only when the hold limit alone forced the release.
          timeout_d = !rel_norm;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt       = valid_q ? (8'b1 << idx_q) : 8'h00;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Testbench for rr_arb8: two instances (HOLD_MAX 16 and 4) share stimulus.
// A reference model pushes the expected outputs per edge into per-instance
// queues; a negedge monitor pops and compares against the DUT outputs.
module tb_rr_arb8;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;

  int checks = 0;
  int errors = 0;

  rr_arb8_if if_a ();
  rr_arb8_if if_b ();

  assign if_a.req  = req;
  assign if_a.done = done;
  assign if_b.req  = req;
  assign if_b.done = done;

  rr_arb8 #(.HOLD_MAX(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  rr_arb8 #(.HOLD_MAX(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  always #5 clk = ~clk;

  // Reference model: who owns the resource, for how long, and where the
  // next search starts.
  int   hold_lim [2] = '{16, 4};
  bit   busy  [2];
  int   owner [2];
  int   held  [2];
  int   nxt   [2];
  bit   tflag [2];
  exp_t q0 [$];
  exp_t q1 [$];

  task automatic model_step(input int d);
    bit rel_norm, rel_to;
    bit found;
    if (!rst_n) begin
      busy[d] = 0; owner[d] = 0; held[d] = 0; nxt[d] = 0; tflag[d] = 0;
    end else if (busy[d]) begin
      rel_norm = done || !req[owner[d]];
      rel_to   = (held[d] + 1 == hold_lim[d]);
      tflag[d] = 0;
      if (rel_norm || rel_to) begin
        busy[d]  = 0;
        nxt[d]   = (owner[d] + 1) % 8;
        tflag[d] = !rel_norm;
      end else begin
        held[d] = held[d] + 1;
      end
    end else begin
      tflag[d] = 0;
      found = 0;
      for (int k = 0; k < 8; k++) begin
        if (!found && req[(nxt[d] + k) % 8]) begin
          found    = 1;
          owner[d] = (nxt[d] + k) % 8;
          busy[d]  = 1;
          held[d]  = 0;
        end
      end
    end
  endtask

  function automatic exp_t model_out(input int d);
    exp_t e;
    logic [7:0] one;
    one     = 8'h01;
    e.gnt   = busy[d] ? (one << owner[d]) : 8'h00;
    e.idx   = 3'(owner[d]);
    e.valid = busy[d];
    e.to    = tflag[d];
    return e;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step(0);
      q0.push_back(model_out(0));
      model_step(1);
      q1.push_back(model_out(1));
    end
  end

  task automatic sb_compare(input int d, input exp_t act);
    exp_t e;
    checks++;
    if (d == 0 ? q0.size() == 0 : q1.size() == 0) begin
      errors++;
      $display("FAIL sb%0d: no expected entry, actual %h", d, act);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    if (!rst_n) e = '0;
    if (act !== e) begin
      errors++;
      $display("FAIL sb%0d t=%0t: actual gnt=%h idx=%0d valid=%b to=%b required gnt=%h idx=%0d valid=%b to=%b",
               d, $time, act.gnt, act.idx, act.valid, act.to, e.gnt, e.idx, e.valid, e.to);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      sb_compare(0, {if_a.gnt, if_a.gnt_idx, if_a.gnt_valid, if_a.timeout});
      sb_compare(1, {if_b.gnt, if_b.gnt_idx, if_b.gnt_valid, if_b.timeout});
    end
  end

  task automatic dchk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset held for 10 cycles with no requests.
    cyc(10);
    rst_n = 1'b1;

    // First arbitration searches from 0: idx 2 wins, then 5 after done.
    req = 8'b0010_0100;
    cyc(1);
    dchk("first_idx", 32'(if_a.gnt_idx), 32'd2);
    dchk("first_gnt", 32'(if_a.gnt), 32'h04);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    dchk("dead_valid", 32'(if_a.gnt_valid), 32'd0);
    cyc(1);
    dchk("second_idx", 32'(if_a.gnt_idx), 32'd5);
    dchk("second_gnt", 32'(if_a.gnt), 32'h20);
    done = 1'b1;
    cyc(1);
    done = 1'b0;

    // Wrap-around: release of 7 moves the pointer to 0.
    req = 8'h80;
    cyc(1);
    dchk("wrap_idx7", 32'(if_a.gnt_idx), 32'd7);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    req = 8'h81;
    cyc(1);
    dchk("wrap_idx0", 32'(if_a.gnt_idx), 32'd0);
    dchk("wrap_gnt", 32'(if_a.gnt), 32'h01);
    req = 8'h00;
    cyc(2);

    // Timeout on the HOLD_MAX=4 instance.
    req = 8'h01;
    cyc(1);
    dchk("to_gnt", 32'(if_b.gnt), 32'h01);
    cyc(3);
    dchk("to_gnt_last", 32'(if_b.gnt), 32'h01);
    cyc(1);
    dchk("to_pulse", 32'(if_b.timeout), 32'd1);
    dchk("to_dead", 32'(if_b.gnt_valid), 32'd0);
    cyc(1);
    dchk("to_regrant", 32'(if_b.gnt), 32'h01);
    dchk("to_pulse_end", 32'(if_b.timeout), 32'd0);

    // done coinciding with cnt==HOLD_MAX-1 is a normal release.
    cyc(3);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    dchk("simul_to", 32'(if_b.timeout), 32'd0);
    dchk("simul_valid", 32'(if_b.gnt_valid), 32'd0);
    cyc(1);

    // Async reset between edges during a grant.
    req = 8'hFF;
    cyc(3);
    #2;
    rst_n = 1'b0;
    #1;
    dchk("arst_gnt", 32'(if_a.gnt), 32'h00);
    dchk("arst_valid", 32'(if_a.gnt_valid), 32'd0);
    dchk("arst_to_b", 32'(if_b.timeout), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1);
    dchk("arst_idx", 32'(if_a.gnt_idx), 32'd0);
    dchk("arst_idx_b", 32'(if_b.gnt_idx), 32'd0);

    // Randomized traffic checked by the scoreboard.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
      end
      cyc(1);
    end
    req  = 8'h00;
    done = 1'b0;
    cyc(3);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter HOLD_MAX, default 16, SHALL set the maximum consecutive cycles a grant is held (legal range 2..256).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 req  input  8  SHALL carry the request lines; bit i is requester i.
REQ-005 done  input  1  SHALL be the release strobe from the current owner, sampled only in GRANT.
REQ-006 gnt  output  8  SHALL be the one-hot grant, decoded from gnt_idx, and all zeros when gnt_valid=0.
REQ-007 gnt_idx  output  3  SHALL be the binary index of the granted requester.
REQ-008 gnt_valid  output  1  SHALL be high while a grant is held.
REQ-009 timeout  output  1  SHALL be a one-cycle pulse marking a forced release at HOLD_MAX.

Function
REQ-010 The FSM SHALL have two states: IDLE and GRANT.
REQ-011 Internal state SHALL comprise a 3-bit priority pointer ptr, an 8-bit hold counter cnt and the registered grant.
REQ-012 In IDLE with req != 0 at edge k, the arbiter SHALL select the first set bit searching ptr, ptr+1, ... mod 8.
REQ-013 At edge k it SHALL then register gnt_idx, set gnt_valid=1, clear cnt to 0 and enter GRANT, so the grant is visible after edge k.
REQ-014 In IDLE with req == 0, outputs and ptr SHALL hold, with gnt=0 and gnt_valid=0.
REQ-015 In GRANT, cnt SHALL increment each cycle; req changes on other bits SHALL be ignored.
REQ-016 Release SHALL occur at an edge where any of the following holds: done=1; req[gnt_idx]=0; cnt==HOLD_MAX-1.
REQ-017 On release the block SHALL enter IDLE, clear gnt and gnt_valid, and set ptr=gnt_idx+1 with 7 wrapping to 0.
REQ-018 gnt_idx SHALL hold its last value in IDLE.
REQ-019 timeout SHALL be high for exactly the cycle after a release caused solely by cnt==HOLD_MAX-1.
REQ-020 If done=1 or req[gnt_idx]=0 coincides with cnt==HOLD_MAX-1, the release SHALL be normal and timeout SHALL stay 0.
REQ-021 Every release SHALL be followed by at least one IDLE cycle with gnt_valid=0; the earliest re-grant is the following edge.
REQ-022 A requester that is the sole requester SHALL be re-granted after that dead cycle, including after a timeout.
REQ-023 gnt SHALL never have more than one bit set, and gnt_valid SHALL equal |gnt at all times.

Reset
REQ-024 While rst_n=0, the block SHALL immediately, without a clock edge, force the following values: state IDLE; ptr=0; cnt=0; gnt=8'h00; gnt_idx=3'd0; gnt_valid=0; timeout=0.
REQ-025 Reset asserted mid-grant SHALL abort the grant with no timeout pulse.
REQ-026 After rst_n deasserts, the first arbitration SHALL search from index 0.

Verification
REQ-027 Reset with req=8'h00 for 10 cycles -> gnt=8'h00, gnt_valid=0, timeout=0 throughout.
REQ-028 After reset, drive req=8'b0010_0100 -> gnt_idx=2 and gnt=8'h04 one edge later. Then pulse done for one cycle -> one dead cycle, then gnt_idx=5 and gnt=8'h20.
REQ-029 Wrap-around: grant idx 7 with req=8'h80, then done -> ptr=0. Then req=8'h81 -> gnt_idx=0 and gnt=8'h01.
REQ-030 Timeout with HOLD_MAX=4: hold req=8'h01 with done=0 -> gnt=8'h01 for 4 cycles, a timeout pulse of 1 cycle, one dead cycle, then gnt=8'h01 again.
REQ-031 Simultaneous events with HOLD_MAX=4: assert done on the cycle cnt==3 -> release with timeout=0.
REQ-032 Async reset mid-operation: drop rst_n between clock edges during a grant -> gnt=8'h00 and gnt_valid=0 before the next edge. After release, req=8'hFF -> gnt_idx=0.
